// File: rtl/mem_dma_if.sv
// mem_dma_if: request/response memory bus shared by the memory controller
// and any additional initiator such as mem_dma.
//
// Handshake: an initiator may raise MEM_exec for exactly one cycle, and only
// in a cycle where it sampled MEM_ready high. MEM_write/MEM_size/MEM_addr/
// MEM_data_out are valid in that cycle. The responder later pulses
// MEM_data_ready for one cycle to complete the transaction. On a read,
// MEM_data_in is valid while MEM_data_ready is high.
//
// Signals:
//   MEM_ready      responder -> initiator  responder idle, exec accepted
//   MEM_exec       initiator -> responder  one-cycle transaction request
//   MEM_write      initiator -> responder  1 = write, 0 = read
//   MEM_size       initiator -> responder  transfer size code
//   MEM_addr       initiator -> responder  transaction address
//   MEM_data_out   initiator -> responder  write data
//   MEM_data_in    responder -> initiator  read data
//   MEM_data_ready responder -> initiator  transaction-complete pulse
interface mem_dma_if;
  logic        MEM_ready;
  logic        MEM_exec;
  logic        MEM_write;
  logic [1:0]  MEM_size;
  logic [15:0] MEM_addr;
  logic [15:0] MEM_data_out;
  logic [15:0] MEM_data_in;
  logic        MEM_data_ready;

  modport master (
    input  MEM_ready, MEM_data_in, MEM_data_ready,
    output MEM_exec, MEM_write, MEM_size, MEM_addr, MEM_data_out
  );

  modport slave (
    output MEM_ready, MEM_data_in, MEM_data_ready,
    input  MEM_exec, MEM_write, MEM_size, MEM_addr, MEM_data_out
  );
endinterface

// File: rtl/mem_dma.sv
// mem_dma: memory-to-memory block copy engine. After a start pulse it copies
// I_len 16-bit words from I_src to I_dst, one bus read followed by one bus
// write per word, holding an arbiter request for the whole copy.
//
// Ports:
//   I_clk, I_reset    clock, synchronous active-high reset
//   I_start           start pulse, honoured only while idle
//   I_src/I_dst/I_len source, destination, word count (latched on start)
//   O_busy            copy in progress
//   O_done            one-cycle completion pulse
//   O_bus_req         bus request to arbiter
//   I_bus_grant       bus grant from arbiter
//   mem               memory bus, initiator side
//   O_state           debug view of the FSM state (state_e encoding)
module mem_dma #(
  parameter logic [1:0] SIZE_WORD = 2'b10,
  parameter int         ADDR_STEP = 2
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_start,
  input  logic [15:0] I_src,
  input  logic [15:0] I_dst,
  input  logic [15:0] I_len,
  output logic        O_busy,
  output logic        O_done,
  output logic        O_bus_req,
  input  logic        I_bus_grant,
  mem_dma_if.master   mem,
  output logic [2:0]  O_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } state_e;

  localparam logic [15:0] STEP = 16'(ADDR_STEP);

  state_e      state_q, state_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] count_q, count_d;
  logic [15:0] buf_q, buf_d;
  logic        exec_q, exec_d;
  logic        write_q, write_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_out_q, data_out_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        bus_req_q, bus_req_d;

  logic        can_issue;
  assign can_issue = I_bus_grant && mem.MEM_ready;

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q    <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      count_q    <= '0;
      buf_q      <= '0;
      exec_q     <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      data_out_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bus_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      count_q    <= count_d;
      buf_q      <= buf_d;
      exec_q     <= exec_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      data_out_q <= data_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bus_req_q  <= bus_req_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    count_d    = count_q;
    buf_d      = buf_q;
    exec_d     = 1'b0;   // exec is a single-cycle pulse
    write_d    = write_q;
    addr_d     = addr_q;
    data_out_d = data_out_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bus_req_d  = bus_req_q;

    case (state_q)
      IDLE: begin
        if (I_start) begin
          src_d   = I_src;
          dst_d   = I_dst;
          count_d = I_len;
          if (I_len == 16'd0) begin
            // Empty copy: report completion without touching the bus.
            state_d = DONE;
          end else begin
            busy_d    = 1'b1;
            bus_req_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        if (can_issue) begin
          exec_d  = 1'b1;
          write_d = 1'b0;
          addr_d  = src_q;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (mem.MEM_data_ready) begin
          buf_d   = mem.MEM_data_in;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        if (can_issue) begin
          exec_d     = 1'b1;
          write_d    = 1'b1;
          addr_d     = dst_q;
          data_out_d = buf_q;
          state_d    = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (mem.MEM_data_ready) begin
          // Addresses wrap naturally at 16 bits.
          src_d   = src_q + STEP;
          dst_d   = dst_q + STEP;
          count_d = count_q - 16'd1;
          state_d = (count_q == 16'd1) ? DONE : RD_REQ;
        end
      end
      DONE: begin
        done_d    = 1'b1;
        busy_d    = 1'b0;
        bus_req_d = 1'b0;
        write_d   = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem.MEM_exec     = exec_q;
  assign mem.MEM_write    = write_q;
  assign mem.MEM_size     = SIZE_WORD;
  assign mem.MEM_addr     = addr_q;
  assign mem.MEM_data_out = data_out_q;
  assign O_busy           = busy_q;
  assign O_done           = done_q;
  assign O_bus_req        = bus_req_q;
  assign O_state          = state_q;

  // buf_q is only consumed through data_out_d; count/src/dst stay internal.
endmodule

// File: tb/tb_mem_dma.sv
// tb_mem_dma: directed bench for mem_dma with a latency-configurable memory
// responder, an expected-transaction scoreboard and a bus monitor.
module tb_mem_dma;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic [15:0] src, dst, len;
  logic        busy, done, bus_req, grant;
  logic [2:0]  state;

  mem_dma_if bus();

  mem_dma dut (
    .I_clk      (clk),
    .I_reset    (rst),
    .I_start    (start),
    .I_src      (src),
    .I_dst      (dst),
    .I_len      (len),
    .O_busy     (busy),
    .O_done     (done),
    .O_bus_req  (bus_req),
    .I_bus_grant(grant),
    .mem        (bus),
    .O_state    (state)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];   // {write, addr, data}; data is 0 for reads
  int exec_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [35:0] got, input logic [35:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic push_rd(input logic [15:0] a);
    exp_q.push_back({1'b0, a, 16'h0000});
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
    exp_q.push_back({1'b1, a, d});
  endtask

  // ---------------- memory responder ----------------
  logic [15:0] mem_arr [0:65535];
  int          lat = 3;
  logic        rsp_idle = 1'b1;
  logic        force_ready_low = 1'b0;
  int          rsp_cnt = 0;
  logic [15:0] r_addr, r_data;
  logic        r_write;

  assign bus.MEM_ready = rsp_idle && !force_ready_low;

  always @(negedge clk) begin
    bus.MEM_data_ready = 1'b0;
    if (rst) begin
      rsp_idle        = 1'b1;
      rsp_cnt         = 0;
      bus.MEM_data_in = 16'h0000;
    end else if (rsp_idle) begin
      if (bus.MEM_exec) begin
        rsp_idle = 1'b0;
        rsp_cnt  = lat;
        r_addr   = bus.MEM_addr;
        r_write  = bus.MEM_write;
        r_data   = bus.MEM_data_out;
      end
    end else begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        if (r_write) mem_arr[r_addr] = r_data;
        else         bus.MEM_data_in = mem_arr[r_addr];
        bus.MEM_data_ready = 1'b1;
        rsp_idle = 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic prev_exec = 1'b0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst) begin
      if (busy !== bus_req) check("busy_eq_bus_req", {35'd0, bus_req}, {35'd0, busy});
      if (bus.MEM_exec) begin
        exec_cnt++;
        check("exec_one_cycle", {35'd0, prev_exec}, 36'd0);
        check("exec_size", {34'd0, bus.MEM_size}, 36'd2);
        if (exp_q.size() == 0) begin
          check("unexpected_exec", {3'd0, bus.MEM_write, bus.MEM_addr, bus.MEM_data_out}, 36'hFFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("exec_txn",
                {3'd0, bus.MEM_write, bus.MEM_addr, bus.MEM_write ? bus.MEM_data_out : 16'h0000},
                {3'd0, e});
        end
      end
      if (done) begin
        done_cnt++;
        check("done_one_cycle", {35'd0, prev_done}, 36'd0);
      end
    end
    prev_exec = bus.MEM_exec;
    prev_done = done;
  end

  // ---------------- driver tasks ----------------
  task automatic start_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    @(negedge clk);
    src = s; dst = d; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max);
    int c = 0;
    while (!done && c < max) begin
      @(negedge clk);
      c++;
    end
    check(name, {35'd0, done}, 36'd1);
    if (done) begin
      check({name, "_busy_low"}, {35'd0, busy}, 36'd0);
      check({name, "_req_low"}, {35'd0, bus_req}, 36'd0);
    end
    repeat (3) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int e0, d0, c;
    logic seen;
    rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0; grant = 1'b1;
    for (int i = 0; i < 65536; i++) mem_arr[i] = 16'h0000;
    mem_arr[16'h2000] = 16'hAAAA;
    mem_arr[16'h2002] = 16'hBBBB;
    mem_arr[16'h2004] = 16'hCCCC;
    mem_arr[16'h4000] = 16'h1234;
    mem_arr[16'hFFFE] = 16'h1111;
    mem_arr[16'h0000] = 16'h2222;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_exec",  {35'd0, bus.MEM_exec}, 36'd0);
    check("rst_write", {35'd0, bus.MEM_write}, 36'd0);
    check("rst_size",  {34'd0, bus.MEM_size}, 36'd2);
    check("rst_addr",  {20'd0, bus.MEM_addr}, 36'd0);
    check("rst_dout",  {20'd0, bus.MEM_data_out}, 36'd0);
    check("rst_flags", {33'd0, busy, done, bus_req}, 36'd0);
    check("rst_state", {33'd0, state}, 36'd0);

    // 3-word copy, latency 3
    e0 = exec_cnt; d0 = done_cnt;
    push_rd(16'h2000); push_wr(16'h3000, 16'hAAAA);
    push_rd(16'h2002); push_wr(16'h3002, 16'hBBBB);
    push_rd(16'h2004); push_wr(16'h3004, 16'hCCCC);
    start_copy(16'h2000, 16'h3000, 16'd3);
    check("t1_busy", {34'd0, busy, bus_req}, 36'd3);
    wait_done("t1_done", 200);
    check("t1_exec_cnt", 36'(exec_cnt - e0), 36'd6);
    check("t1_done_cnt", 36'(done_cnt - d0), 36'd1);
    check("t1_mem0", {20'd0, mem_arr[16'h3000]}, 36'hAAAA);
    check("t1_mem1", {20'd0, mem_arr[16'h3002]}, 36'hBBBB);
    check("t1_mem2", {20'd0, mem_arr[16'h3004]}, 36'hCCCC);
    check("t1_q_empty", 36'(exp_q.size()), 36'd0);

    // len == 0: done two cycles after start, no bus traffic
    e0 = exec_cnt;
    @(negedge clk);
    src = 16'h1000; dst = 16'h1100; len = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t2_done_c1", {34'd0, done, bus_req}, 36'd0);
    @(negedge clk);
    check("t2_done_c2", {34'd0, done, bus_req}, 36'd2);
    check("t2_busy", {35'd0, busy}, 36'd0);
    @(negedge clk);
    check("t2_done_c3", {35'd0, done}, 36'd0);
    check("t2_exec_cnt", 36'(exec_cnt - e0), 36'd0);

    // grant withheld for 10 cycles
    grant = 1'b0;
    e0 = exec_cnt;
    push_rd(16'h4000); push_wr(16'h5000, 16'h1234);
    start_copy(16'h4000, 16'h5000, 16'd1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.MEM_exec) seen = 1'b1;
      @(negedge clk);
    end
    check("t3_no_exec", {35'd0, seen}, 36'd0);
    check("t3_req_held", {35'd0, bus_req}, 36'd1);
    grant = 1'b1;
    @(negedge clk);
    check("t3_exec_after_grant", {19'd0, bus.MEM_exec, bus.MEM_addr}, {19'd0, 1'b1, 16'h4000});
    wait_done("t3_done", 100);
    check("t3_mem", {20'd0, mem_arr[16'h5000]}, 36'h1234);
    check("t3_exec_cnt", 36'(exec_cnt - e0), 36'd2);

    // address wrap
    push_rd(16'hFFFE); push_wr(16'h7FFE, 16'h1111);
    push_rd(16'h0000); push_wr(16'h8000, 16'h2222);
    start_copy(16'hFFFE, 16'h7FFE, 16'd2);
    wait_done("t4_done", 200);
    check("t4_mem0", {20'd0, mem_arr[16'h7FFE]}, 36'h1111);
    check("t4_mem1", {20'd0, mem_arr[16'h8000]}, 36'h2222);
    check("t4_q_empty", 36'(exp_q.size()), 36'd0);

    // reset during WR_WAIT
    push_rd(16'h2000); push_wr(16'h6000, 16'hAAAA);
    start_copy(16'h2000, 16'h6000, 16'd2);
    c = 0;
    while (state != 3'd4 && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("t5_reach_wr_wait", {33'd0, state}, 36'd4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_exec", {35'd0, bus.MEM_exec}, 36'd0);
    check("t5_rst_flags", {33'd0, busy, done, bus_req}, 36'd0);
    check("t5_rst_state", {33'd0, state}, 36'd0);
    check("t5_rst_write", {35'd0, bus.MEM_write}, 36'd0);
    @(negedge clk);
    rst = 1'b0;
    check("t5_q_empty", 36'(exp_q.size()), 36'd0);
    push_rd(16'h2004); push_wr(16'h6100, 16'hCCCC);
    start_copy(16'h2004, 16'h6100, 16'd1);
    wait_done("t5_done", 100);
    check("t5_mem", {20'd0, mem_arr[16'h6100]}, 36'hCCCC);

    // MEM_ready low during RD_REQ, extra starts while busy
    e0 = exec_cnt; d0 = done_cnt;
    force_ready_low = 1'b1;
    push_rd(16'h2000); push_wr(16'h6200, 16'hAAAA);
    push_rd(16'h2002); push_wr(16'h6202, 16'hBBBB);
    start_copy(16'h2000, 16'h6200, 16'd2);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      src = 16'h0100; dst = 16'h0900; len = 16'd7;
      start = (i % 2 == 0);
      if (bus.MEM_exec) seen = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    check("t6_no_exec", {35'd0, seen}, 36'd0);
    check("t6_state_rd_req", {33'd0, state}, 36'd1);
    force_ready_low = 1'b0;
    @(negedge clk);
    check("t6_exec_after_ready", {19'd0, bus.MEM_exec, bus.MEM_addr}, {19'd0, 1'b1, 16'h2000});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t6_done", 200);
    check("t6_exec_cnt", 36'(exec_cnt - e0), 36'd4);
    check("t6_done_cnt", 36'(done_cnt - d0), 36'd1);
    check("t6_mem0", {20'd0, mem_arr[16'h6200]}, 36'hAAAA);
    check("t6_mem1", {20'd0, mem_arr[16'h6202]}, 36'hBBBB);
    check("t6_idle", {33'd0, state}, 36'd0);

    // final report
    check("final_q_empty", 36'(exp_q.size()), 36'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_dma.md
# mem_dma

Memory-to-memory copy engine acting as a second initiator on the core memory bus (MEM_* handshake). It drives the same request/response protocol the system memory controller answers: it issues read and write transactions and consumes MEM_ready / MEM_data_ready. After a start pulse it copies a block of 16-bit words from a source region to a destination region, one read followed by one write per word. Bus ownership is obtained through a request/grant pair from an external arbiter.

## Interface
Parameters:
- SIZE_WORD, 2'b10, MEM_size code driven for every transaction
- ADDR_STEP, 2, address increment per word

Ports:
- I_clk  in  1  clock
- I_reset  in  1  synchronous, active-high reset
- I_start  in  1  start pulse; sampled only in IDLE
- I_src  in  16  source start address, latched on start
- I_dst  in  16  destination start address, latched on start
- I_len  in  16  word count, latched on start
- O_busy  out  1  high from the cycle after accepted start until DONE exits
- O_done  out  1  one-cycle completion pulse
- O_bus_req  out  1  bus request to arbiter
- I_bus_grant  in  1  bus granted
- MEM_ready  in  1  responder idle and able to accept exec
- MEM_exec  out  1  one-cycle transaction request
- MEM_write  out  1  1 = write, 0 = read
- MEM_size  out  2  transfer size, always SIZE_WORD
- MEM_addr  out  16  transaction address
- MEM_data_out  out  16  write data
- MEM_data_in  in  16  read data, valid while MEM_data_ready high
- MEM_data_ready  in  1  one-cycle transaction-complete pulse (reads and writes)

## Operation
- All outputs registered. Reset values: MEM_exec 0, MEM_write 0, MEM_size SIZE_WORD, MEM_addr 0, MEM_data_out 0, O_busy 0, O_done 0, O_bus_req 0; state IDLE; internal src/dst/count/buffer 0.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
- IDLE: on I_start latch I_src, I_dst, I_len. If I_len == 0 go to DONE (no bus traffic). Else O_busy <= 1, O_bus_req <= 1, go to RD_REQ.
- RD_REQ: when I_bus_grant && MEM_ready: MEM_exec <= 1, MEM_write <= 0, MEM_addr <= src, go to RD_WAIT. Otherwise hold, MEM_exec 0.
- RD_WAIT: MEM_exec <= 0. On MEM_data_ready: buffer <= MEM_data_in, go to WR_REQ.
- WR_REQ: when I_bus_grant && MEM_ready: MEM_exec <= 1, MEM_write <= 1, MEM_addr <= dst, MEM_data_out <= buffer, go to WR_WAIT.
- WR_WAIT: MEM_exec <= 0; MEM_addr, MEM_write, MEM_data_out held. On MEM_data_ready: src += ADDR_STEP, dst += ADDR_STEP, count -= 1; if count becomes 0 go to DONE else RD_REQ.
- DONE: O_done <= 1 for one cycle, O_busy <= 0, O_bus_req <= 0, MEM_write <= 0, go to IDLE.
- MEM_data_ready honoured only in RD_WAIT/WR_WAIT; ignored elsewhere.
- I_bus_grant checked only in *_REQ states; grant loss after exec does not abort the transaction in flight.
- Address arithmetic modulo 2^16 (0xFFFE + 2 = 0x0000); no bounds checks.
- I_start while not IDLE ignored; latched parameters unaffected.
- O_bus_req stays high continuously from start acceptance to DONE, including between transactions.

## Timing
- MEM_exec high exactly one cycle per transaction; address/write/data/size valid in that cycle and held until next *_REQ issue.
- Exec issued in the cycle after a *_REQ state samples grant && MEM_ready.
- Next *_REQ state entered the cycle after MEM_data_ready is seen.
- Per word: 2 transactions, each costing 1 issue cycle + responder latency + 1 cycle.
- len == 0: O_done high 2 cycles after I_start (IDLE -> DONE -> pulse).
- Reset mid-operation: at the reset edge all outputs return to reset values, state IDLE; transaction in flight abandoned (responder is reset by the same I_reset).

## Test plan
- Copy src=0x2000, dst=0x3000, len=3 with responder latency 3; memory 0x2000..0x2004 = 0xAAAA,0xBBBB,0xCCCC -> exec sequence R2000,W3000,R2002,W3002,R2004,W3004 (6 exec pulses, each 1 cycle), destination matches, single O_done pulse, O_busy/O_bus_req drop together.
- len=0, start -> O_done pulse 2 cycles later, zero MEM_exec, O_bus_req never high.
- len=1, I_bus_grant low 10 cycles after start -> no MEM_exec; grant high -> read exec next cycle, copy completes.
- src=0xFFFE, dst=0x7FFE, len=2 -> second read addr 0x0000, second write addr 0x8000.
- I_reset asserted in WR_WAIT -> next cycle MEM_exec 0, O_busy 0, O_bus_req 0; fresh start len=1 completes normally.
- MEM_ready held low 5 cycles during RD_REQ plus I_start pulses while busy -> no exec until MEM_ready high; extra starts ignored, transfer count unchanged.
